// File: rtl/hazard_tracker.sv
// hazard_tracker: shadow E/M/W pipeline of decode info that produces the
// load-use stall and every forwarding-mux select for the five-stage MIPS core.
module hazard_tracker #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_A1,
    input  logic [4:0]       D_A2,
    input  logic [4:0]       D_A3,
    input  logic             D_RegWrite,
    input  logic [1:0]       D_rs_use,
    input  logic [1:0]       D_rt_use,
    input  logic [1:0]       D_new,
    output logic             stall,
    output logic [1:0]       D_rs_fwd,
    output logic [1:0]       D_rt_fwd,
    output logic [1:0]       E_rs_fwd,
    output logic [1:0]       E_rt_fwd,
    output logic             M_rt_fwd,
    output logic [CNT_W-1:0] stall_cnt
);

    // One shadow slot: what the real pipeline register for that stage holds,
    // reduced to the fields that matter for hazards.
    typedef struct packed {
        logic       valid;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        logic       reg_write;
        logic [1:0] new_stage;
    } entry_t;

    // Stage indices double as the forward-select codes of the matching stage.
    localparam logic [1:0] STAGE_E = 2'd1;
    localparam logic [1:0] STAGE_M = 2'd2;
    localparam logic [1:0] STAGE_W = 2'd3;
    localparam logic [1:0] USE_NONE = 2'd3;

    entry_t e_q;
    entry_t m_q;
    entry_t w_q;
    entry_t d_entry;

    // Remaining cycles before this entry's result reaches a pipeline register.
    function automatic logic [1:0] t_new(input entry_t ent, input logic [1:0] stage_idx);
        logic [1:0] remaining;
        remaining = 2'd0;
        if (ent.new_stage > stage_idx) begin
            remaining = ent.new_stage - stage_idx;
        end
        return remaining;
    endfunction

    // True when this entry will write register rnum (bubbles and $0 never match).
    function automatic logic produces(input entry_t ent, input logic [4:0] rnum);
        return ent.valid && ent.reg_write && (ent.a3 != 5'd0) && (ent.a3 == rnum);
    endfunction

    // A D-stage read must wait if a not-yet-ready producer in E or M would
    // deliver its result later than the reader needs it.
    function automatic logic read_stalls(input logic [4:0] rnum, input logic [1:0] use_code,
                                         input entry_t ent_e, input entry_t ent_m);
        logic hit;
        hit = 1'b0;
        if ((use_code != USE_NONE) && (rnum != 5'd0)) begin
            if (produces(ent_e, rnum) && (t_new(ent_e, STAGE_E) > use_code)) begin
                hit = 1'b1;
            end
            if (produces(ent_m, rnum) && (t_new(ent_m, STAGE_M) > use_code)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // D-stage select: nearest producer among E, M, W decides; a not-ready
    // nearest producer forces the GRF path (the stall covers that case).
    function automatic logic [1:0] d_select(input logic [4:0] rnum, input entry_t ent_e,
                                            input entry_t ent_m, input entry_t ent_w);
        logic [1:0] sel;
        sel = 2'd0;
        if (rnum == 5'd0) begin
            sel = 2'd0;
        end else if (produces(ent_e, rnum)) begin
            sel = (t_new(ent_e, STAGE_E) == 2'd0) ? STAGE_E : 2'd0;
        end else if (produces(ent_m, rnum)) begin
            sel = (t_new(ent_m, STAGE_M) == 2'd0) ? STAGE_M : 2'd0;
        end else if (produces(ent_w, rnum)) begin
            sel = (t_new(ent_w, STAGE_W) == 2'd0) ? STAGE_W : 2'd0;
        end
        return sel;
    endfunction

    // E-stage select: same nearest-first rule, looking only at M then W.
    function automatic logic [1:0] e_select(input logic [4:0] rnum, input entry_t ent_m,
                                            input entry_t ent_w);
        logic [1:0] sel;
        sel = 2'd0;
        if (rnum == 5'd0) begin
            sel = 2'd0;
        end else if (produces(ent_m, rnum)) begin
            sel = (t_new(ent_m, STAGE_M) == 2'd0) ? STAGE_M : 2'd0;
        end else if (produces(ent_w, rnum)) begin
            sel = (t_new(ent_w, STAGE_W) == 2'd0) ? STAGE_W : 2'd0;
        end
        return sel;
    endfunction

    // Package the D inputs as a shadow entry; a new code of 00 means E.
    always_comb begin
        d_entry           = '0;
        d_entry.valid     = 1'b1;
        d_entry.a1        = D_A1;
        d_entry.a2        = D_A2;
        d_entry.a3        = D_A3;
        d_entry.reg_write = D_RegWrite;
        d_entry.new_stage = (D_new == 2'd0) ? STAGE_E : D_new;
    end

    // Stall decision and all forward selects, purely from the current entries.
    always_comb begin
        stall    = read_stalls(D_A1, D_rs_use, e_q, m_q) |
                   read_stalls(D_A2, D_rt_use, e_q, m_q);
        D_rs_fwd = d_select(D_A1, e_q, m_q, w_q);
        D_rt_fwd = d_select(D_A2, e_q, m_q, w_q);
        E_rs_fwd = e_select(e_q.a1, m_q, w_q);
        E_rt_fwd = e_select(e_q.a2, m_q, w_q);
        M_rt_fwd = (e_select(m_q.a2, '0, w_q) == STAGE_W);
    end

    // Advance the shadow pipeline; a stall drops a bubble into E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= stall ? entry_t'('0) : d_entry;
            m_q <= e_q;
            w_q <= m_q;
        end
    end

    // Count stalled cycles, wrapping naturally at the counter width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed instruction sequences with hand-computed
// stall / forward expectations for hazard_tracker.
module tb_hazard_tracker;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [4:0]       D_A1 = '0;
    logic [4:0]       D_A2 = '0;
    logic [4:0]       D_A3 = '0;
    logic             D_RegWrite = 1'b0;
    logic [1:0]       D_rs_use = 2'd3;
    logic [1:0]       D_rt_use = 2'd3;
    logic [1:0]       D_new = 2'd1;
    logic             stall;
    logic [1:0]       D_rs_fwd;
    logic [1:0]       D_rt_fwd;
    logic [1:0]       E_rs_fwd;
    logic [1:0]       E_rt_fwd;
    logic             M_rt_fwd;
    logic [CNT_W-1:0] stall_cnt;

    int total_checks = 0;
    int bad_checks = 0;

    hazard_tracker #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .D_A1       (D_A1),
        .D_A2       (D_A2),
        .D_A3       (D_A3),
        .D_RegWrite (D_RegWrite),
        .D_rs_use   (D_rs_use),
        .D_rt_use   (D_rt_use),
        .D_new      (D_new),
        .stall      (stall),
        .D_rs_fwd   (D_rs_fwd),
        .D_rt_fwd   (D_rt_fwd),
        .E_rs_fwd   (E_rs_fwd),
        .E_rt_fwd   (E_rt_fwd),
        .M_rt_fwd   (M_rt_fwd),
        .stall_cnt  (stall_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                                 input logic rw, input logic [1:0] rs_use, input logic [1:0] rt_use,
                                 input logic [1:0] nw);
        D_A1       = a1;
        D_A2       = a2;
        D_A3       = a3;
        D_RegWrite = rw;
        D_rs_use   = rs_use;
        D_rt_use   = rt_use;
        D_new      = nw;
    endtask

    task automatic applyNop();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 2'd3, 2'd3, 2'd1);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            applyNop();
            nextCycle();
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
        checkOutput({tag, "_drs"}, 32'(D_rs_fwd), 32'd0);
        checkOutput({tag, "_drt"}, 32'(D_rt_fwd), 32'd0);
        checkOutput({tag, "_ers"}, 32'(E_rs_fwd), 32'd0);
        checkOutput({tag, "_ert"}, 32'(E_rt_fwd), 32'd0);
        checkOutput({tag, "_mrt"}, 32'(M_rt_fwd), 32'd0);
        checkOutput({tag, "_cnt"}, stall_cnt, 32'd0);
    endtask

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequences.
    initial begin
        // Reset held for three cycles while D carries hazardous traffic.
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: applyStimulus(5'd0, 5'd0, 5'd1, 1'b1, 2'd1, 2'd1, 2'd2);
                1: applyStimulus(5'd1, 5'd1, 5'd0, 1'b0, 2'd0, 2'd0, 2'd1);
                default: applyStimulus(5'd0, 5'd0, 5'd2, 1'b1, 2'd1, 2'd3, 2'd3);
            endcase
            @(negedge clk);
            checkQuiet("rst_hold");
            nextCycle();
        end
        reset = 1'b1;
        applyStimulus(5'd1, 5'd2, 5'd0, 1'b0, 2'd0, 2'd0, 2'd1);
        @(negedge clk);
        checkQuiet("rst_empty");
        nextCycle();
        drain();

        // addu $1 then beq $1: one stall, then forward from M.
        applyStimulus(5'd0, 5'd0, 5'd1, 1'b1, 2'd1, 2'd1, 2'd2);
        nextCycle();
        applyStimulus(5'd1, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 2'd1);
        @(negedge clk);
        checkOutput("beq_stall", 32'(stall), 32'd1);
        checkOutput("beq_fwd_wait", 32'(D_rs_fwd), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("beq_nostall", 32'(stall), 32'd0);
        checkOutput("beq_fwd_m", 32'(D_rs_fwd), 32'd2);
        checkOutput("beq_cnt", stall_cnt, 32'd1);
        nextCycle();
        applyNop();
        @(negedge clk);
        checkOutput("beq_e_fwd_w", 32'(E_rs_fwd), 32'd3);
        nextCycle();
        drain();

        // lw $2 then addu reading $2 in E.
        applyStimulus(5'd0, 5'd0, 5'd2, 1'b1, 2'd1, 2'd3, 2'd3);
        nextCycle();
        applyStimulus(5'd2, 5'd0, 5'd7, 1'b1, 2'd1, 2'd1, 2'd2);
        @(negedge clk);
        checkOutput("lwuse_stall", 32'(stall), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("lwuse_release", 32'(stall), 32'd0);
        checkOutput("lwuse_dfwd", 32'(D_rs_fwd), 32'd0);
        nextCycle();
        applyNop();
        @(negedge clk);
        checkOutput("lwuse_efwd_w", 32'(E_rs_fwd), 32'd3);
        checkOutput("lwuse_cnt", stall_cnt, 32'd2);
        nextCycle();
        drain();

        // lw $3 then sw of $3: no stall, store data forwarded from W.
        applyStimulus(5'd0, 5'd0, 5'd3, 1'b1, 2'd1, 2'd3, 2'd3);
        nextCycle();
        applyStimulus(5'd0, 5'd3, 5'd0, 1'b0, 2'd1, 2'd2, 2'd1);
        @(negedge clk);
        checkOutput("sw_nostall", 32'(stall), 32'd0);
        checkOutput("sw_dfwd", 32'(D_rt_fwd), 32'd0);
        nextCycle();
        applyNop();
        @(negedge clk);
        checkOutput("sw_efwd_wait", 32'(E_rt_fwd), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("sw_mfwd_w", 32'(M_rt_fwd), 32'd1);
        nextCycle();
        drain();

        // jal then jr $31: ready in E immediately.
        applyStimulus(5'd0, 5'd0, 5'd31, 1'b1, 2'd3, 2'd3, 2'd1);
        nextCycle();
        applyStimulus(5'd31, 5'd0, 5'd0, 1'b0, 2'd0, 2'd3, 2'd1);
        @(negedge clk);
        checkOutput("jr_nostall", 32'(stall), 32'd0);
        checkOutput("jr_fwd_e", 32'(D_rs_fwd), 32'd1);
        nextCycle();
        drain();

        // Writes to $0 are never producers.
        applyStimulus(5'd5, 5'd0, 5'd0, 1'b1, 2'd1, 2'd3, 2'd2);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 2'd1);
        @(negedge clk);
        checkOutput("r0_nostall", 32'(stall), 32'd0);
        checkOutput("r0_fwd", 32'(D_rs_fwd), 32'd0);
        nextCycle();
        drain();

        // lw $4 in M, addu $4 in E: the nearer addu decides.
        applyStimulus(5'd0, 5'd0, 5'd4, 1'b1, 2'd1, 2'd3, 2'd3);
        nextCycle();
        applyStimulus(5'd0, 5'd0, 5'd4, 1'b1, 2'd1, 2'd1, 2'd2);
        @(negedge clk);
        checkOutput("near_setup", 32'(stall), 32'd0);
        nextCycle();
        applyStimulus(5'd4, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 2'd1);
        @(negedge clk);
        checkOutput("near_stall", 32'(stall), 32'd1);
        checkOutput("near_fwd_wait", 32'(D_rs_fwd), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("near_nostall", 32'(stall), 32'd0);
        checkOutput("near_fwd_m", 32'(D_rs_fwd), 32'd2);
        nextCycle();
        drain();

        // Reads marked as unused never stall, even on a pending producer.
        applyStimulus(5'd0, 5'd0, 5'd6, 1'b1, 2'd1, 2'd1, 2'd2);
        nextCycle();
        applyStimulus(5'd6, 5'd6, 5'd0, 1'b0, 2'd3, 2'd3, 2'd1);
        @(negedge clk);
        checkOutput("nouse_nostall", 32'(stall), 32'd0);
        checkOutput("nouse_rs_fwd", 32'(D_rs_fwd), 32'd0);
        checkOutput("nouse_rt_fwd", 32'(D_rt_fwd), 32'd0);
        checkOutput("total_cnt", stall_cnt, 32'd3);
        nextCycle();
        drain();

        // Asynchronous reset in the middle of a stall.
        applyStimulus(5'd0, 5'd0, 5'd9, 1'b1, 2'd1, 2'd1, 2'd2);
        nextCycle();
        applyStimulus(5'd9, 5'd0, 5'd0, 1'b0, 2'd0, 2'd0, 2'd1);
        @(negedge clk);
        checkOutput("arst_pre_stall", 32'(stall), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        checkQuiet("arst_now");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("arst_hold_cnt", stall_cnt, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("arst_rel_stall", 32'(stall), 32'd0);
        nextCycle();
        checkOutput("arst_rel_cnt", stall_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Consumes the per-instruction decode information produced in D: source/destination register numbers, use-stage codes and new-stage code.
- Tracks in-flight producers through the E, M and W stages in its own shadow pipeline.
- Generates the pipeline stall and all forwarding-mux selects for the five-stage MIPS core.
- Sits beside the pipeline registers and drives the D/E/M stall and mux logic.

Parameters:
CNT_W, 32, width of the stall performance counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
D_A1  input  5  rs number of the instruction in D
D_A2  input  5  rt number of the instruction in D
D_A3  input  5  destination register of the instruction in D
D_RegWrite  input  1  instruction in D writes GRF
D_rs_use  input  2  stage reading rs: 00 D, 01 E, 10 M, 11 none
D_rt_use  input  2  stage reading rt, same coding
D_new  input  2  stage whose input register holds the result: 01 E, 10 M, 11 W (00 is treated as 01)
stall  output  1  freeze PC and the D register; insert a bubble into E
D_rs_fwd  output  2  D-stage rs source: 00 GRF, 01 E reg, 10 M reg, 11 W reg
D_rt_fwd  output  2  same for rt
E_rs_fwd  output  2  E-stage rs source: 00 pipeline value, 10 M reg, 11 W reg
E_rt_fwd  output  2  same for rt
M_rt_fwd  output  1  M-stage store data: 0 pipeline value, 1 W reg
stall_cnt  output  CNT_W  number of stall cycles since reset

Behaviour:
- Shadow entries E, M, W each hold {valid, A1, A2, A3, RegWrite, new}, with stage index S = 1, 2, 3 respectively.
- Reset (reset = 0, asynchronous): all entries invalid; stall_cnt = 0.
  - Outputs are combinational from the entries, so stall = 0 and all fwd = 0 while reset is held.
- Each rising edge with stall = 0: E <= D inputs (valid = 1), M <= E, W <= M.
- Each rising edge with stall = 1: E <= bubble (valid = 0), M <= E, W <= M; D inputs are not captured.
- stall_cnt increments by 1 on each edge where stall = 1 and wraps at 2^CNT_W.
- An entry is a producer iff valid & RegWrite & A3 != 0.
- Tnew = max(new - S, 0). An entry is ready iff Tnew = 0 (i.e. new <= S).
- Tuse for the instruction in D = its use code, 0..2; code 11 never stalls.
- stall = 1 iff, for rs or rt with use != 11 and reg != 0, the E or M entry is a producer with A3 == reg and Tnew > Tuse.
  - The W entry never stalls.
- stall is combinational, with no added latency.
- Forward selection, all consumers:
  - Scan producers from the nearest older stage outward; the first with A3 == reg decides.
  - If that producer is ready, select its stage code; otherwise select 0.
  - Register 0 always selects 0.
  - D consumers scan E, M, W. E consumers use the E entry's A1/A2 and scan M, W. M_rt_fwd uses the M entry's A2 and checks W only.
- Simultaneous match in E and M: the E entry decides, even if it is not ready.
- Bubbles (valid = 0) never match.

Test Plan:
- reset held low for 3 cycles during activity -> stall = 0, all fwd = 0, stall_cnt = 0; after release, E/M/W are empty.
- addu $1 (new = 10, RegWrite = 1) followed by beq with rs = $1 (use 00) -> stall = 1 for exactly 1 cycle; in the next cycle addu is in M, stall = 0, D_rs_fwd = 10; stall_cnt = 1.
- lw $2 (new = 11) followed by addu with rs = $2 (use 01):
  - stall for 1 cycle.
  - Next cycle: lw in M has Tnew 1, which is not > 1, so no stall.
  - Following cycle: addu in E, lw in W, E_rs_fwd = 11.
- lw $3 followed by sw with rt = $3 (use 10) -> no stall; when sw is in M and lw in W, M_rt_fwd = 1.
- jal (A3 = 31, new = 01) followed by jr with rs = $31 (use 00) -> no stall, D_rs_fwd = 01.
- ori with A3 = $0, RegWrite = 1, followed by beq with rs = $0 -> stall = 0, D_rs_fwd = 00.
- addu $4 (new = 10) in E and lw $4 (new = 11) in M, then beq with rs = $4 (use 00) -> E entry decides (nearest): stall = 1.
  - Next cycle: addu in M decides over lw in W, so D_rs_fwd = 10.
